// File: rtl/tetris_pkg.sv
// Shared playfield geometry constants, board storage type and FSM state encoding.
package tetris_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned CELL_PX    = 16;
  localparam int unsigned BOARD_X0   = 240;
  localparam int unsigned BOARD_Y0   = 80;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned COL_W      = 4;
  localparam int unsigned BOARD_W_PX = BOARD_COLS * CELL_PX;
  localparam int unsigned BOARD_H_PX = BOARD_ROWS * CELL_PX;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

endpackage

// File: rtl/playfield_geom.sv
// Pure combinational mapping of a screen pixel onto the board: inside test,
// grid-line test and the cell coordinates the pixel falls in.
module playfield_geom
  import tetris_pkg::*;
(
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  output logic               inside_o,
  output logic               grid_o,
  output logic [ROW_W-1:0]   row_o,
  output logic [COL_W-1:0]   col_o
);

  logic [COORD_W-1:0] lx;
  logic [COORD_W-1:0] ly;

  always_comb begin
    lx = draw_x_i - COORD_W'(BOARD_X0);
    ly = draw_y_i - COORD_W'(BOARD_Y0);

    inside_o = (draw_x_i >= COORD_W'(BOARD_X0))
            && (draw_x_i <  COORD_W'(BOARD_X0 + BOARD_W_PX))
            && (draw_y_i >= COORD_W'(BOARD_Y0))
            && (draw_y_i <  COORD_W'(BOARD_Y0 + BOARD_H_PX));

    // Lines on every cell's top/left edge plus the closing right/bottom border.
    grid_o = inside_o && ((lx[3:0] == 4'd0) || (ly[3:0] == 4'd0)
                       || (lx == COORD_W'(BOARD_W_PX - 1))
                       || (ly == COORD_W'(BOARD_H_PX - 1)));

    row_o = ly[8:4];
    col_o = lx[7:4];
  end

endmodule

// File: rtl/playfield_renderer.sv
// Tetris playfield: 10x20 occupancy board with cell writes, row-clear shifting
// and a registered per-pixel grid/block classifier for the colour stage.
module playfield_renderer
  import tetris_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [COORD_W-1:0]    DrawX,
  input  logic [COORD_W-1:0]    DrawY,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [COL_W-1:0]      wr_col,
  input  logic                  wr_data,
  input  logic                  clr_valid,
  output logic                  clr_ready,
  input  logic [ROW_W-1:0]      clr_row,
  input  logic                  board_clr,
  output logic                  is_grid,
  output logic                  is_block,
  output logic                  busy,
  output logic [BOARD_ROWS-1:0] rows_full
);

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      ptr_q, ptr_d;
  board_t                board_q, board_d;
  logic                  ready_q, busy_q;
  logic                  grid_q, block_q;
  logic [BOARD_ROWS-1:0] full_q, full_d;
  logic                  block_d;

  logic                  pix_inside;
  logic                  pix_grid;
  logic [ROW_W-1:0]      pix_row;
  logic [COL_W-1:0]      pix_col;

  playfield_geom u_geom (
    .draw_x_i (DrawX),
    .draw_y_i (DrawY),
    .inside_o (pix_inside),
    .grid_o   (pix_grid),
    .row_o    (pix_row),
    .col_o    (pix_col)
  );

  // Next-state: clear beats write in IDLE; SHIFT walks ptr up to row 0; board_clr overrides all.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    board_d = board_q;

    case (state_q)
      ST_IDLE: begin
        if (clr_valid) begin
          if (clr_row < ROW_W'(BOARD_ROWS)) begin
            ptr_d   = clr_row;
            state_d = ST_SHIFT;
          end
        end else if (wr_valid && (wr_row < ROW_W'(BOARD_ROWS))
                              && (wr_col < COL_W'(BOARD_COLS))) begin
          board_d[wr_row][wr_col] = wr_data;
        end
      end
      ST_SHIFT: begin
        if (ptr_q != '0) begin
          board_d[ptr_q] = board_q[ptr_q - ROW_W'(1)];
          ptr_d          = ptr_q - ROW_W'(1);
        end else begin
          board_d[0] = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (board_clr) begin
      board_d = '0;
      ptr_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // Pixel classification and row-full flags read the board as it stands this cycle.
  always_comb begin
    block_d = pix_inside && !pix_grid && board_q[pix_row][pix_col];
    full_d  = '0;
    for (int r = 0; r < int'(BOARD_ROWS); r++) begin
      full_d[r] = &board_q[r];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      board_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      grid_q  <= 1'b0;
      block_q <= 1'b0;
      full_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      board_q <= board_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d == ST_SHIFT);
      grid_q  <= pix_grid;
      block_q <= block_d;
      full_q  <= full_d;
    end
  end

  assign wr_ready  = ready_q;
  assign clr_ready = ready_q;
  assign busy      = busy_q;
  assign is_grid   = grid_q;
  assign is_block  = block_q;
  assign rows_full = full_q;

endmodule

// File: tb/tb_playfield_renderer.sv
// Self-checking bench for playfield_renderer: board/pixel model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_playfield_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_row;
  logic [3:0]  wr_col;
  logic        wr_data;
  logic        clr_valid, clr_ready;
  logic [4:0]  clr_row;
  logic        board_clr;
  logic        is_grid, is_block, busy;
  logic [19:0] rows_full;

  playfield_renderer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .clr_valid (clr_valid),
    .clr_ready (clr_ready),
    .clr_row   (clr_row),
    .board_clr (board_clr),
    .is_grid   (is_grid),
    .is_block  (is_block),
    .busy      (busy),
    .rows_full (rows_full)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model state: board as a plain 2-D array and the shift in progress.
  bit        m_cell [20][10];
  int        m_ptr = 0;
  bit        m_shift = 0;
  bit        m_valid = 0;
  bit        e_grid, e_block, e_ready, e_busy;
  bit [19:0] e_full;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void pix_model(input int x, input int y, output bit g, output bit b);
    int lx, ly;
    lx = x - 240;
    ly = y - 80;
    g = 1'b0;
    b = 1'b0;
    if (x >= 240 && x < 400 && y >= 80 && y < 400) begin
      g = (lx % 16 == 0) || (ly % 16 == 0) || (lx == 159) || (ly == 319);
      b = !g && m_cell[ly / 16][lx / 16];
    end
  endfunction

  function automatic bit row_is_full(input int r);
    for (int c = 0; c < 10; c++) if (!m_cell[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) m_cell[r][c] = 1'b0;
  endtask

  // Model update at every active edge.
  initial begin
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        model_clear_board();
        m_shift = 1'b0;
        m_ptr   = 0;
        m_valid = 1'b0;
      end else begin
        pix_model(int'(DrawX), int'(DrawY), e_grid, e_block);
        for (int r = 0; r < 20; r++) e_full[r] = row_is_full(r);
        if (board_clr) begin
          model_clear_board();
          m_shift = 1'b0;
        end else if (!m_shift) begin
          if (clr_valid) begin
            if (int'(clr_row) < 20) begin
              m_shift = 1'b1;
              m_ptr   = int'(clr_row);
            end
          end else if (wr_valid && int'(wr_row) < 20 && int'(wr_col) < 10) begin
            m_cell[wr_row][wr_col] = wr_data;
          end
        end else if (m_ptr != 0) begin
          for (int c = 0; c < 10; c++) m_cell[m_ptr][c] = m_cell[m_ptr-1][c];
          m_ptr--;
        end else begin
          for (int c = 0; c < 10; c++) m_cell[0][c] = 1'b0;
          m_shift = 1'b0;
        end
        e_ready = !m_shift;
        e_busy  = m_shift;
        m_valid = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (m_valid && !Reset) begin
        cmp("model_is_grid",   int'(is_grid),   int'(e_grid));
        cmp("model_is_block",  int'(is_block),  int'(e_block));
        cmp("model_rows_full", int'(rows_full), int'(e_full));
        cmp("model_wr_ready",  int'(wr_ready),  int'(e_ready));
        cmp("model_clr_ready", int'(clr_ready), int'(e_ready));
        cmp("model_busy",      int'(busy),      int'(e_busy));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input bit d);
    wr_valid = 1'b1;
    wr_row   = 5'(r);
    wr_col   = 4'(c);
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
  endtask

  int n;

  initial begin
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = 1'b0;
    clr_valid = 1'b0; clr_row = '0; board_clr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    cmp("reset_is_grid",   int'(is_grid),   0);
    cmp("reset_is_block",  int'(is_block),  0);
    cmp("reset_rows_full", int'(rows_full), 0);
    cmp("reset_busy",      int'(busy),      0);

    // Reset release and first pixel.
    Reset = 1'b0;
    pixel(245, 85);
    cmp("post_reset_is_grid",  int'(is_grid),   0);
    cmp("post_reset_is_block", int'(is_block),  0);
    cmp("post_reset_wr_ready", int'(wr_ready),  1);
    cmp("post_reset_clr_ready", int'(clr_ready), 1);
    cmp("post_reset_rows_full", int'(rows_full), 0);

    // Single cell write, then block and grid pixels.
    write_cell(0, 0, 1'b1);
    pixel(241, 81);
    cmp("cell00_is_block", int'(is_block), 1);
    cmp("cell00_is_grid",  int'(is_grid),  0);
    pixel(256, 81);
    cmp("gridline_is_grid",  int'(is_grid),  1);
    cmp("gridline_is_block", int'(is_block), 0);

    // Fill row 19 after placing (18,3); rows_full lags the last write by a cycle.
    write_cell(18, 3, 1'b1);
    for (int c = 0; c < 10; c++) write_cell(19, c, 1'b1);
    cmp("row19_full_lag",  int'(rows_full[19]), 0);
    step();
    cmp("row19_full",      int'(rows_full[19]), 1);

    clr_valid = 1'b1;
    clr_row   = 5'd19;
    step();
    clr_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    cmp("shift_cycles_row19", n, 20);
    pixel(293, 389);
    cmp("cell19_3_after_shift", int'(is_block), 1);
    pixel(293, 373);
    cmp("cell18_3_after_shift", int'(is_block), 0);
    cmp("row19_not_full", int'(rows_full[19]), 0);

    // Simultaneous clear and write: clear wins, write waits out the shift.
    clr_valid = 1'b1; clr_row = 5'd2;
    wr_valid  = 1'b1; wr_row = 5'd5; wr_col = 4'd5; wr_data = 1'b1;
    step();
    clr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 100) begin
      n++;
      step();
    end
    cmp("wr_blocked_cycles", n, 3);
    step();
    wr_valid = 1'b0;
    pixel(325, 165);
    cmp("deferred_write_block", int'(is_block), 1);

    // board_clr during a shift.
    for (int c = 0; c < 10; c++) write_cell(3, c, 1'b1);
    clr_valid = 1'b1; clr_row = 5'd10;
    step();
    clr_valid = 1'b0;
    step();
    step();
    cmp("pre_boardclr_busy", int'(busy), 1);
    board_clr = 1'b1;
    step();
    board_clr = 1'b0;
    cmp("boardclr_busy",     int'(busy),     0);
    cmp("boardclr_wr_ready", int'(wr_ready), 1);
    pixel(245, 133);
    cmp("boardclr_rows_full", int'(rows_full), 0);
    cmp("boardclr_cell3_0",   int'(is_block),  0);

    // Reset in the middle of a shift.
    for (int c = 0; c < 10; c++) write_cell(3, c, 1'b1);
    DrawX = 10'd245; DrawY = 10'd133;
    clr_valid = 1'b1; clr_row = 5'd15;
    step();
    clr_valid = 1'b0;
    step();
    cmp("pre_reset_block",    int'(is_block),     1);
    cmp("pre_reset_row3full", int'(rows_full[3]), 1);
    cmp("pre_reset_busy",     int'(busy),         1);
    Reset = 1'b1;
    #1;
    cmp("midshift_reset_busy",      int'(busy),      0);
    cmp("midshift_reset_block",     int'(is_block),  0);
    cmp("midshift_reset_rows_full", int'(rows_full), 0);
    step();
    Reset = 1'b0;
    step();
    cmp("post_midreset_wr_ready", int'(wr_ready), 1);
    pixel(245, 133);
    cmp("post_midreset_cell3_0", int'(is_block), 0);

    // Fully occupied board and the board edges.
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) write_cell(r, c, 1'b1);
    step();
    cmp("full_board_rows_full", int'(rows_full), 32'h000F_FFFF);
    pixel(400, 200);
    cmp("x400_is_grid",  int'(is_grid),  0);
    cmp("x400_is_block", int'(is_block), 0);
    pixel(300, 400);
    cmp("y400_is_grid",  int'(is_grid),  0);
    cmp("y400_is_block", int'(is_block), 0);
    pixel(399, 200);
    cmp("x399_is_grid",  int'(is_grid),  1);
    pixel(239, 200);
    cmp("x239_is_grid",  int'(is_grid),  0);
    cmp("x239_is_block", int'(is_block), 0);
    pixel(250, 79);
    cmp("y79_is_block",  int'(is_block), 0);
    pixel(250, 90);
    cmp("full_is_block", int'(is_block), 1);
    pixel(250, 399);
    cmp("y399_is_grid",  int'(is_grid),  1);

    // Mixed traffic including out-of-range writes and clears, checked by the model.
    for (int i = 0; i < 600; i++) begin
      DrawX     = 10'($urandom_range(230, 410));
      DrawY     = 10'($urandom_range(70, 410));
      wr_valid  = 1'($urandom_range(0, 1));
      wr_row    = 5'($urandom_range(0, 21));
      wr_col    = 4'($urandom_range(0, 11));
      wr_data   = 1'($urandom_range(0, 1));
      clr_valid = ($urandom_range(0, 40) == 0);
      clr_row   = 5'($urandom_range(0, 21));
      board_clr = ($urandom_range(0, 300) == 0);
      step();
    end
    wr_valid = 1'b0; clr_valid = 1'b0; board_clr = 1'b0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
